// File: rtl/write_mem.sv
`default_nettype none
// ============================================================================
// Module   : write_mem
// Brief    : Logic analyzer capture writer. Arms on command, writes probe
//            samples into a circular buffer, then writes post_count samples
//            after a trigger and freezes. Define TRIGGER_EDGE_EN for a
//            rising-edge trigger; without it the trigger is level-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module write_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] post_count,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [DATA_WIDTH-1:0] memory [MEMORY_SIZE],
  output logic                  armed,
  output logic                  triggered,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [ADDR_WIDTH-1:0]   trig_addr_q;
  logic [ADDR_WIDTH-1:0]   remain_q;
  logic                    armed_q;
  logic                    triggered_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEMORY_SIZE];
  logic                    trig_evt;
  logic                    wr_en;

`ifdef TRIGGER_EDGE_EN
  // Previous trigger level, sampled in every state so a level already high
  // at arm time must fall and rise again before it counts.
  logic trig_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trigger;
    end
  end

  assign trig_evt = trigger & ~trig_prev_q;
`else
  assign trig_evt = trigger;
`endif

  // State resets asynchronously to IDLE, so no write can happen while reset is low.
  assign wr_en = (state_q == S_ARMED) || (state_q == S_CAPTURE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[waddr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      remain_q    <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_q <= S_ARMED;
            waddr_q <= '0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        S_ARMED: begin
          waddr_q <= waddr_q + ADDR_WIDTH'(1);
          if (trig_evt) begin
            trig_addr_q <= waddr_q;
            remain_q    <= post_count;
            armed_q     <= 1'b0;
            if (post_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_CAPTURE;
              triggered_q <= 1'b1;
            end
          end
        end

        S_CAPTURE: begin
          waddr_q  <= waddr_q + ADDR_WIDTH'(1);
          remain_q <= remain_q - ADDR_WIDTH'(1);
          // This write consumes the last remaining post-trigger slot.
          if (remain_q == ADDR_WIDTH'(1)) begin
            state_q     <= S_DONE;
            triggered_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign waddr     = waddr_q;
  assign trig_addr = trig_addr_q;
  assign memory    = mem_q;
  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_write_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_mem
// Brief    : Directed, table-driven bench for write_mem (edge or level trigger).
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_mem;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MS = 16;

  typedef struct {
    logic          arm;
    logic          trig;
    logic [AW-1:0] pc;
    logic          ex_armed;
    logic          ex_trig;
    logic          ex_done;
    logic [AW-1:0] ex_waddr;
    logic [AW-1:0] ex_taddr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [AW-1:0] post_count = '0;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic [DW-1:0] memory [MS];
  logic          armed;
  logic          triggered;
  logic          done;

  int total = 0;
  int bad   = 0;
  vec_t vecs [12];

  always #5 clk = ~clk;

  write_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEMORY_SIZE(MS)
  ) dut (
    .clk       (clk),
    .reset     (reset_n),
    .arm       (arm),
    .trigger   (trigger),
    .i_data    (i_data),
    .post_count(post_count),
    .waddr     (waddr),
    .trig_addr (trig_addr),
    .memory    (memory),
    .armed     (armed),
    .triggered (triggered),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic a, input logic t, input logic d,
                           input logic [AW-1:0] w, input logic [AW-1:0] ta);
    chk({tag, " flags"}, {29'd0, armed, triggered, done}, {29'd0, a, t, d});
    chk({tag, " waddr"}, {28'd0, waddr}, {28'd0, w});
    chk({tag, " trig_addr"}, {28'd0, trig_addr}, {28'd0, ta});
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [DW-1:0] exp);
    chk($sformatf("%s mem[%0d]", tag, a), {24'd0, memory[a]}, {24'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // arm trig pc | armed trig done waddr taddr ; i_data = 0x10 + index
    vecs[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0};
    vecs[6]  = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 4'd5, 4'd4};
    vecs[7]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd4};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd4};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd4};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd4};
    vecs[11] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4};

    // Reset state
    #2 reset_n = 1'b0;
    #6 chk_state("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Basic capture, ignored controls, arm from DONE
    for (int i = 0; i < 12; i++) begin
      arm        = vecs[i].arm;
      trigger    = vecs[i].trig;
      post_count = vecs[i].pc;
      i_data     = DW'(16 + i);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ex_armed, vecs[i].ex_trig,
                vecs[i].ex_done, vecs[i].ex_waddr, vecs[i].ex_taddr);
    end
    for (int a = 0; a < 8; a++) chk_mem("basic", a, DW'(8'h12 + a));
    arm = 1'b0;

    // Wrap-around: trigger on the 21st armed sample, post_count = 15
    for (int k = 0; k < 36; k++) begin
      i_data     = DW'(8'hA0 + k);
      trigger    = (k == 20);
      post_count = (k == 20) ? AW'(15) : AW'(0);
      arm        = (k == 25);
      step();
      if (k == 19) chk_state("wrap pre", 1'b1, 1'b0, 1'b0, 4'd4, 4'd4);
      else if (k == 20) chk_state("wrap trig", 1'b0, 1'b1, 1'b0, 4'd5, 4'd4);
      else if (k > 20 && k < 35) chk_state($sformatf("wrap cap%0d", k), 1'b0, 1'b1, 1'b0, AW'(k + 1), 4'd4);
    end
    trigger = 1'b0;
    arm     = 1'b0;
    chk_state("wrap done", 1'b0, 1'b0, 1'b1, 4'd4, 4'd4);
    chk_mem("wrap", 4, 8'hB4);
    chk_mem("wrap", 5, 8'hB5);
    chk_mem("wrap", 3, 8'hC3);

    // Zero post-trigger count
    arm = 1'b1;
    step();
    chk_state("zero arm", 1'b1, 1'b0, 1'b0, 4'd0, 4'd4);
    arm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_data     = DW'(8'h30 + k);
      trigger    = (k == 2);
      post_count = 4'd0;
      step();
    end
    trigger = 1'b0;
    chk_state("zero done", 1'b0, 1'b0, 1'b1, 4'd3, 4'd2);
    chk_mem("zero", 2, 8'h32);
    chk_mem("zero", 3, 8'hC3);
    i_data = 8'h99;
    step();
    chk_state("zero hold", 1'b0, 1'b0, 1'b1, 4'd3, 4'd2);
    chk_mem("zero hold", 3, 8'hC3);

    // Trigger held high from before arm
    trigger    = 1'b1;
    arm        = 1'b1;
    post_count = 4'd1;
    step();
    chk_state("hold arm", 1'b1, 1'b0, 1'b0, 4'd0, 4'd2);
    arm = 1'b0;
`ifdef TRIGGER_EDGE_EN
    step();
    chk_state("edge a", 1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
    step();
    chk_state("edge b", 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    trigger = 1'b0;
    step();
    chk_state("edge c", 1'b1, 1'b0, 1'b0, 4'd3, 4'd2);
    trigger = 1'b1;
    step();
    chk_state("edge d", 1'b0, 1'b1, 1'b0, 4'd4, 4'd3);
    trigger = 1'b0;
    step();
    chk_state("edge e", 1'b0, 1'b0, 1'b1, 4'd5, 4'd3);
`else
    step();
    chk_state("level a", 1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    trigger = 1'b0;
    step();
    chk_state("level b", 1'b0, 1'b0, 1'b1, 4'd2, 4'd0);
`endif

    // Reset in the middle of a capture
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_data     = DW'(8'h40 + k);
      trigger    = (k == 2);
      post_count = 4'd5;
      step();
    end
    trigger = 1'b0;
    chk_state("rst pre", 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    chk_mem("rst pre", 3, 8'h43);
    #2 reset_n = 1'b0;
    #1 chk_state("rst async", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    arm    = 1'b1;
    i_data = 8'h77;
    step();
    chk_state("rst held", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    chk_mem("rst held", 0, 8'h40);
    #2 reset_n = 1'b1;
    arm = 1'b0;
    step();
    step();
    chk_state("rst after", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    chk_mem("rst after", 0, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_mem.md
# write_mem

Capture-side writer for the logic analyzer sample buffer. Arms on command, continuously writes probe samples into a circular memory, accepts a trigger, writes a programmable number of post-trigger samples, then freezes. Owns the sample memory and the write pointer `waddr`. The read side consumes both and reads in order, oldest sample first, starting at `waddr`.

## Interface
- `DATA_WIDTH`, 8, sample width in bits
- `ADDR_WIDTH`, 4, buffer address width
- `MEMORY_SIZE`, 16, buffer depth; must equal 2**`ADDR_WIDTH`
- `clk`  input  1  sole clock; all state changes on its rising edge
- `reset`  input  1  asynchronous, active-low reset
- `arm`  input  1  start a capture; honoured only in IDLE or DONE
- `trigger`  input  1  trigger condition from the probe logic
- `i_data`  input  `DATA_WIDTH`  probe sample
- `post_count`  input  `ADDR_WIDTH`  samples to write after the trigger sample; sampled on the trigger cycle
- `waddr`  output  `ADDR_WIDTH`  next write address; in DONE this is the oldest sample
- `trig_addr`  output  `ADDR_WIDTH`  address holding the trigger sample
- `memory`  output  `DATA_WIDTH` x `MEMORY_SIZE`  sample buffer
- `armed`  output  1  high in ARMED
- `triggered`  output  1  high in CAPTURE
- `done`  output  1  high in DONE

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DONE. Outputs are decoded directly from state and registers.
- IDLE
  - No writes.
  - `arm`=1: go to ARMED and clear `waddr` to 0.
  - `trigger` is ignored, including when it arrives in the same cycle as `arm`.
- ARMED
  - Every cycle: `memory[waddr]` <= `i_data`, then `waddr` <= `waddr`+1. The pointer wraps modulo `MEMORY_SIZE`.
  - On a trigger event, that cycle's sample is written as normal. In the same edge: `trig_addr` <= `waddr`, the remaining counter <= `post_count`, and the FSM goes to CAPTURE. If `post_count`=0, it goes straight to DONE instead.
- CAPTURE
  - Writes and increments the pointer every cycle.
  - The remaining counter decrements on each write. The write that takes it from 1 to 0 is the last one; the FSM goes to DONE on that edge.
  - `trigger` is ignored.
- DONE
  - No writes. `waddr` and `memory` hold their values.
  - `arm`=1 starts a new capture, exactly as from IDLE.
- `arm` in ARMED or CAPTURE is ignored. The only way to abort a capture is `reset`.
- `post_count` maximum is `MEMORY_SIZE`-1, so the trigger sample is never overwritten.
- Arithmetic: all pointer and counter arithmetic is `ADDR_WIDTH` bits and wraps naturally.

## Timing
- Reset values:
  - state IDLE; `waddr`=0, `trig_addr`=0, `armed`=0, `triggered`=0, `done`=0; remaining counter 0; edge register 0.
  - `memory` is not reset.
- Reset mid-capture: the FSM returns to IDLE immediately and asynchronously. No write occurs on any edge while `reset`=0.
- Write latency: a sample presented at edge N lands in `memory` at edge N, visible from N+1.
- Trigger to done:
  - The trigger sample and `post_count` further samples are written on consecutive edges, `post_count`+1 writes in total.
  - `done` rises on the edge of the last write.
- Final pointer: in DONE, `waddr` = (`trig_addr` + `post_count` + 1) mod `MEMORY_SIZE`.
- `armed` rises the edge after `arm`. The first sample is written on that next edge, at address 0.

## Configuration
- `TRIGGER_EDGE_EN` defined:
  - A trigger event is a rising edge of `trigger`: `trigger`=1 while the registered previous value is 0.
  - The previous-value register samples `trigger` every cycle in every state and resets to 0.
  - A trigger already high when arming does not fire until it falls and rises again.
- `TRIGGER_EDGE_EN` undefined: a trigger event is `trigger`=1 (level-sensitive) in any ARMED cycle. No edge register.

## Test plan
- Reset mid-capture: pull `reset` low in CAPTURE -> `waddr`=0, `trig_addr`=0, `armed`/`triggered`/`done`=0 immediately; after release, no writes until `arm`.
- Basic capture:
  - Stimulus: `i_data` = cycle count, pulse `arm`, assert `trigger` on the 5th armed cycle, `post_count`=3.
  - Response: `trig_addr`=4, `memory[4..7]` hold consecutive counts, `done` on the 8th write edge, `waddr`=8.
- Wrap-around:
  - Stimulus: `MEMORY_SIZE`=16, trigger on the 21st armed sample, `post_count`=15.
  - Response: `trig_addr`=4, `waddr`=4 in DONE, and `memory[4]` holds the trigger sample.
- Zero post-trigger: `post_count`=0 -> exactly one write at `trig_addr`, `done` on the same edge, `waddr`=`trig_addr`+1.
- Ignored controls:
  - `arm`+`trigger` together in IDLE -> ARMED only, no trigger.
  - `arm` during CAPTURE -> no restart, `waddr` unaffected.
  - `arm` in DONE -> ARMED, `waddr`=0.
- Edge vs level: `trigger` held high from before `arm`:
  - With `TRIGGER_EDGE_EN` -> no trigger until a 0->1 transition.
  - Without it -> triggers on the first armed cycle, `trig_addr`=0.
